// File: rtl/msg_assembler.sv
// rtl/msg_assembler.sv - packs a framed word stream into fixed-width message records (optional stats: MSG_ASM_STATS_EN)
module msg_assembler #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4,
    parameter int LEN_W  = $clog2(WORDS+1)
`ifdef MSG_ASM_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_v,
    output logic                    s_r,
    input  logic [WORD_W-1:0]       s_d,
    input  logic                    s_last,
    output logic                    m_v,
    input  logic                    m_r,
    output logic [WORD_W*WORDS-1:0] m_d,
    output logic [LEN_W-1:0]        m_len,
    output logic                    m_trunc
`ifdef MSG_ASM_STATS_EN
    ,
    output logic [CNT_W-1:0]        msg_cnt,
    output logic [CNT_W-1:0]        trunc_cnt
`endif
);

    localparam int MSG_W = WORD_W * WORDS;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic               disc_q, disc_d;
    logic [MSG_W-1:0]   data_q, data_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               trunc_q, trunc_d;
    logic               handshake;

    // Handshake/ready flags come straight from the state register, so neither
    // side sees a combinational path from the other side's request.
    assign s_r       = (state_q != HOLD);
    assign m_v       = (state_q == HOLD);
    assign handshake = (state_q == HOLD) && m_r;
    assign m_d       = data_q;
    assign m_len     = len_q;
    assign m_trunc   = trunc_q;

    // Next-state: lane fill, record hold, and tail discard of over-long frames
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        disc_d  = disc_q;
        data_d  = data_q;
        len_d   = len_q;
        trunc_d = trunc_q;
        case (state_q)
            FILL: begin
                if (s_v) begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (LEN_W'(k) == idx_q) begin
                            data_d[k*WORD_W +: WORD_W] = s_d;
                        end
                    end
                    if (s_last) begin
                        state_d = HOLD;
                        len_d   = idx_q + LEN_W'(1);
                        trunc_d = 1'b0;
                    end else if (idx_q == LEN_W'(WORDS-1)) begin
                        // Record is full but the frame continues: emit what we
                        // have and swallow the rest of the frame afterwards.
                        state_d = HOLD;
                        len_d   = LEN_W'(WORDS);
                        trunc_d = 1'b1;
                        disc_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            HOLD: begin
                if (m_r) begin
                    // Clearing lanes here keeps unused upper lanes of the next
                    // (shorter) record at zero.
                    data_d  = '0;
                    idx_d   = '0;
                    len_d   = '0;
                    trunc_d = 1'b0;
                    state_d = disc_q ? DISCARD : FILL;
                end
            end
            DISCARD: begin
                if (s_v && s_last) begin
                    state_d = FILL;
                    disc_d  = 1'b0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and record registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            disc_q  <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            disc_q  <= disc_d;
            data_q  <= data_d;
            len_q   <= len_d;
            trunc_q <= trunc_d;
        end
    end

`ifdef MSG_ASM_STATS_EN
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [CNT_W-1:0] trunc_cnt_q, trunc_cnt_d;

    assign msg_cnt   = msg_cnt_q;
    assign trunc_cnt = trunc_cnt_q;

    // Saturating record and truncation counters, bumped on each handshake
    always_comb begin
        msg_cnt_d   = msg_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        if (handshake && (msg_cnt_q != {CNT_W{1'b1}})) begin
            msg_cnt_d = msg_cnt_q + CNT_W'(1);
        end
        if (handshake && trunc_q && (trunc_cnt_q != {CNT_W{1'b1}})) begin
            trunc_cnt_d = trunc_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            msg_cnt_q   <= msg_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: doc/msg_assembler.md
# msg_assembler

Upstream neighbour of the message FIFO: packs a narrow word stream (e.g. MAC/UDP payload words) into fixed-width message records and presents them on a valid/ready interface that connects directly to the FIFO write port. Each input frame, delimited by `s_last`, becomes exactly one output record. Short frames are zero-padded; over-long frames are truncated and flagged.

## Interface
Parameters:
- `WORD_W`, 32: input word width.
- `WORDS`, 4: words per record; record width `MSG_W = WORD_W*WORDS` (default 128).
- `LEN_W`, `$clog2(WORDS+1)`: width of the word-count field.
- `CNT_W`, 16: statistics counter width (only used with `MSG_ASM_STATS_EN`).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_v` in 1: input word valid.
- `s_r` out 1: input word ready.
- `s_d` in `WORD_W`: input word.
- `s_last` in 1: final word of the frame.
- `m_v` out 1: record valid; connects to FIFO `in_v`.
- `m_r` in 1: record ready; connects to FIFO `in_r`.
- `m_d` out `MSG_W`: record; word k occupies bits `[k*WORD_W +: WORD_W]`.
- `m_len` out `LEN_W`: number of valid words in `m_d`, 1..`WORDS`.
- `m_trunc` out 1: the frame had more than `WORDS` words; extra words were dropped.
- `msg_cnt` out `CNT_W`: records emitted (only with `MSG_ASM_STATS_EN`).
- `trunc_cnt` out `CNT_W`: truncated records emitted (only with `MSG_ASM_STATS_EN`).

## Operation
- The state machine has three states: FILL (reset state), HOLD, and DISCARD.
- Internal state consists of the word index `idx` (0..`WORDS-1`) and a pending-discard flag `disc`.
- FILL:
  - `s_r`=1 and `m_v`=0.
  - On an accepted word (`s_v && s_r`), the word is written to lane `idx` and `idx` increments.
  - If `s_last`: go to HOLD with `m_len = idx+1` and `m_trunc` = 0.
  - Else, if `idx == WORDS-1`: go to HOLD with `m_len = WORDS`, `m_trunc` = 1, and `disc` = 1.
- HOLD:
  - `s_r`=0 and `m_v`=1.
  - `m_d`, `m_len` and `m_trunc` are stable until the handshake.
  - On `m_v && m_r`: clear all lanes to zero and set `idx` = 0. Go to DISCARD if `disc`, else go to FILL.
- DISCARD:
  - `s_r`=1 and `m_v`=0.
  - Accepted words are dropped.
  - The state returns to FILL on the cycle after accepting a word with `s_last`=1; `disc` clears at that point.
- Lanes at or above `m_len` always read zero.
- A frame of exactly `WORDS` words with `s_last` on word `WORDS-1` is not truncated.
- `m_trunc` = 1 is only possible when `m_len` = `WORDS`.
- `m_v` never depends combinationally on `m_r`.
- `s_r` never depends combinationally on `s_v`.
- Reset values: state FILL; `idx` 0; `disc` 0; `s_r` 1; `m_v` 0; `m_d` 0; `m_len` 0; `m_trunc` 0; counters 0.
- Reset asserted mid-frame or in HOLD discards the partial or held record; no record is emitted for it.

## Timing
- Latency: `m_v` rises on the cycle after the edge that accepts the frame's final (or `WORDS`-th) word.
- Throughput, when `m_r` is held at 1: an n-word frame (n ≤ `WORDS`) occupies n+1 cycles, because HOLD is one cycle.
- `s_r` falls on the same edge that `m_v` rises.
- `s_r` rises on the edge that completes the `m_v`/`m_r` handshake.
- If `m_r`=0, HOLD lasts indefinitely; input back-pressure is total.
- When fed by the FIFO's `in_r`, the FIFO overflow flag never asserts, because `m_v` is only asserted as a held request.

## Configuration
- `MSG_ASM_STATS_EN` defined:
  - `msg_cnt` and `trunc_cnt` ports exist.
  - `msg_cnt` increments on every `m_v && m_r` handshake.
  - `trunc_cnt` increments on every handshake where `m_trunc` = 1.
  - Both counters saturate at `2**CNT_W-1` and clear only on `rst`.
- `MSG_ASM_STATS_EN` undefined: both ports and the counter logic are absent; all other behaviour is identical.

## Test plan
- 1-word frame `s_d`=0xA5A5A5A5 with `s_last`, `m_r`=1 -> one cycle later: `m_v`=1, `m_d`=0x...0000_A5A5A5A5 (upper 96 bits zero), `m_len`=1, `m_trunc`=0.
- 4-word frame 0x1, 0x2, 0x3, 0x4 with `s_last` on 0x4 -> `m_d`=0x00000004_00000003_00000002_00000001, `m_len`=4, `m_trunc`=0.
- 6-word frame 0x10..0x15 -> record with words 0x10..0x13, `m_len`=4, `m_trunc`=1. Words 0x14 and 0x15 are accepted and dropped; the next frame starts cleanly in lane 0. With stats: `msg_cnt`=1, `trunc_cnt`=1.
- 2-word frame with `m_r`=0 for 10 cycles -> `m_v` held at 1 and `s_r`=0 throughout, record unchanged, no input accepted. With `m_r`=1, the handshake occurs and `s_r`=1 on the next cycle.
- Assert `rst` after word 2 of a 3-word frame -> no record emitted, outputs at their reset values. The next 1-word frame yields `m_len`=1 with the upper lanes zero.
- With the stats macro and `CNT_W`=2 -> 5 frames give `msg_cnt`=3 (saturated).
